// File: rtl/cdc_pkg.sv
// Shared types and constants for the toggle-handshake bus crossing (sender and receiver).
package cdc_pkg;

  typedef enum logic [1:0] {
    RESYNC   = 2'd0,
    IDLE     = 2'd1,
    WAIT_ACK = 2'd2
  } cdc_tx_state_t;

  localparam int XFER_CNT_W = 16;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/cdc_bus_sender_ack_sync.sv
// Multi-flop synchroniser bringing the receiver's ack toggle into the sender clock domain.
module ack_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_reg[0] <= 1'b0;
    else       sync_reg[0] <= async_in;
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_reg[gi] <= 1'b0;
        else       sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  assign sync_out = sync_reg[STAGES-1];

endmodule

// File: rtl/cdc_bus_sender.sv
// Sends a WIDTH-bit word to a foreign clock domain with a toggle req/ack handshake;
// the data bus is held stable from the req toggle until the synchronised ack matches.
module cdc_bus_sender
  import cdc_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      bus_data,
  output logic                  bus_req,
  input  logic                  bus_ack,
  output logic                  timeout_err,
  output logic [XFER_CNT_W-1:0] xfer_count
);

  localparam int TO_W = cnt_width(TIMEOUT_CYCLES);
  localparam int RS_W = cnt_width(SYNC_STAGES);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
  localparam logic [RS_W-1:0] RS_MAX = RS_W'(SYNC_STAGES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  cdc_tx_state_t         state_reg, state_next;
  logic [RS_W-1:0]       resync_cnt_reg, resync_cnt_next;
  logic [TO_W-1:0]       timeout_cnt_reg, timeout_cnt_next;
  logic [WIDTH-1:0]      data_reg, data_next;
  logic                  req_reg, req_next;
  logic                  timeout_err_reg, timeout_err_next;
  logic [XFER_CNT_W-1:0] xfer_count_reg, xfer_count_next;
  logic                  ack_s;
  logic                  match;

  ack_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(bus_ack),
    .sync_out(ack_s)
  );

  assign match = (ack_s == req_reg);

  always_comb begin
    state_next       = state_reg;
    resync_cnt_next  = resync_cnt_reg;
    timeout_cnt_next = timeout_cnt_reg;
    data_next        = data_reg;
    req_next         = req_reg;
    timeout_err_next = timeout_err_reg;
    xfer_count_next  = xfer_count_reg;

    case (state_reg)
      RESYNC: begin
        // Let the synchroniser flush, then wait out any stale ack from an unreset receiver.
        if (resync_cnt_reg != RS_MAX) begin
          resync_cnt_next = resync_cnt_reg + 1'b1;
        end else if (match) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (in_valid) begin
          data_next        = in_data;
          req_next         = ~req_reg;
          timeout_cnt_next = '0;
          state_next       = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (match) begin
          xfer_count_next = xfer_count_reg + 1'b1;
          state_next      = IDLE;
        end else if (TO_EN && (timeout_cnt_reg != TO_MAX)) begin
          // The transfer is never abandoned; the counter just saturates and flags.
          timeout_cnt_next = timeout_cnt_reg + 1'b1;
          if (timeout_cnt_reg == TO_MAX - 1'b1) timeout_err_next = 1'b1;
        end
      end

      default: state_next = RESYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= RESYNC;
      resync_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
      data_reg        <= '0;
      req_reg         <= 1'b0;
      timeout_err_reg <= 1'b0;
      xfer_count_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      resync_cnt_reg  <= resync_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
      data_reg        <= data_next;
      req_reg         <= req_next;
      timeout_err_reg <= timeout_err_next;
      xfer_count_reg  <= xfer_count_next;
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign bus_data    = data_reg;
  assign bus_req     = req_reg;
  assign timeout_err = timeout_err_reg;
  assign xfer_count  = xfer_count_reg;

endmodule
